rv32im_muldiv: RTL and testbench

//  Iterative RV32M multiply/divide unit; multi-cycle counterpart to the single-cycle rv32im_alu.

---
 rtl/rv32im_muldiv_if.sv | 25 ++
 rtl/rv32im_muldiv.sv | 141 ++++++++++++++
 tb/tb_rv32im_muldiv.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv32im_muldiv_if.sv
// Request/response channel between the execute stage and the iterative RV32M unit.
// The master issues operations and collects results; the slave is the multiply/divide unit.
interface rv32im_muldiv_if #(
    parameter int XLEN = 32
);
    logic            flush;
    logic            req_valid;
    logic            req_ready;
    logic [2:0]      op_funct3;
    logic [XLEN-1:0] operand_1;
    logic [XLEN-1:0] operand_2;
    logic            resp_valid;
    logic            resp_ready;
    logic [XLEN-1:0] result;

    modport master (
        output flush, req_valid, op_funct3, operand_1, operand_2, resp_ready,
        input  req_ready, resp_valid, result
    );

    modport slave (
        input  flush, req_valid, op_funct3, operand_1, operand_2, resp_ready,
        output req_ready, resp_valid, result
    );
endinterface

// File: rtl/rv32im_muldiv.sv
// Iterative RV32M multiply/divide: shift-add multiply and restoring divide, one bit per cycle,
// on operand magnitudes with sign fix-up at the end. Divide-by-zero and overflow bypass the loop.
module rv32im_muldiv #(
    parameter int XLEN = 32
) (
    input logic             clk_i,
    input logic             rst_i,
    rv32im_muldiv_if.slave  bus
);
    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state_reg, state_next;
    logic [2:0]      funct3_reg;
    logic            neg_reg;
    logic [CW-1:0]   count_reg;
    logic [XLEN-1:0] hi_reg, lo_reg, m_reg, result_reg;

    logic            accept, fast;
    logic            sgn1, sgn2, s1, s2, signed_div, div_zero, div_ovf, neg_in;
    logic [XLEN-1:0] abs1, abs2, fast_result;
    logic [XLEN:0]   mul_sum, div_shift, div_diff;
    logic [XLEN-1:0] hi_step, lo_step, result_next;
    logic [2*XLEN-1:0] prod;

    // Request decode: which operands are signed, and whether the loop can be skipped.
    always_comb begin
        sgn1       = (bus.op_funct3 == 3'b001) || (bus.op_funct3 == 3'b010) ||
                     (bus.op_funct3 == 3'b100) || (bus.op_funct3 == 3'b110);
        sgn2       = (bus.op_funct3 == 3'b001) || (bus.op_funct3 == 3'b100) ||
                     (bus.op_funct3 == 3'b110);
        signed_div = (bus.op_funct3 == 3'b100) || (bus.op_funct3 == 3'b110);
        s1         = sgn1 & bus.operand_1[XLEN-1];
        s2         = sgn2 & bus.operand_2[XLEN-1];
        abs1       = s1 ? -bus.operand_1 : bus.operand_1;
        abs2       = s2 ? -bus.operand_2 : bus.operand_2;
        // REM follows the dividend's sign; MUL*/DIV negate when the signs differ.
        neg_in     = (bus.op_funct3[2] & bus.op_funct3[1]) ? s1 : (s1 ^ s2);
        div_zero   = (bus.operand_2 == '0);
        div_ovf    = signed_div && (bus.operand_1 == MIN_INT) && (bus.operand_2 == '1);
        fast       = bus.op_funct3[2] & (div_zero | div_ovf);
        if (div_zero)
            fast_result = bus.op_funct3[1] ? bus.operand_1 : '1;
        else
            fast_result = bus.op_funct3[1] ? '0 : MIN_INT;
        accept     = bus.req_valid & bus.req_ready & ~bus.flush;
    end

    // One radix-2 step for whichever operation is in flight.
    always_comb begin
        mul_sum   = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, m_reg} : '0);
        div_shift = {hi_reg, lo_reg[XLEN-1]};
        div_diff  = div_shift - {1'b0, m_reg};
        if (funct3_reg[2]) begin
            if (!div_diff[XLEN]) begin
                hi_step = div_diff[XLEN-1:0];
                lo_step = {lo_reg[XLEN-2:0], 1'b1};
            end else begin
                hi_step = div_shift[XLEN-1:0];
                lo_step = {lo_reg[XLEN-2:0], 1'b0};
            end
        end else begin
            hi_step = mul_sum[XLEN:1];
            lo_step = {mul_sum[0], lo_reg[XLEN-1:1]};
        end
    end

    // Final sign fix-up and result selection, used on the last iteration only.
    always_comb begin
        prod = {hi_step, lo_step};
        if (neg_reg)
            prod = -prod;
        if (!funct3_reg[2])
            result_next = (funct3_reg[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        else if (funct3_reg[1])
            result_next = neg_reg ? -hi_step : hi_step;
        else
            result_next = neg_reg ? -lo_step : lo_step;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        if (bus.flush) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE:    if (accept) state_next = fast ? DONE : BUSY;
                BUSY:    if (count_reg == '0) state_next = DONE;
                DONE:    if (bus.resp_ready) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        bus.req_ready  = (state_reg == IDLE);
        bus.resp_valid = (state_reg == DONE);
        bus.result     = result_reg;
    end

    // Datapath: magnitudes and sign flag captured at accept, iterated while BUSY.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            funct3_reg <= '0;
            neg_reg    <= 1'b0;
            count_reg  <= '0;
            hi_reg     <= '0;
            lo_reg     <= '0;
            m_reg      <= '0;
            result_reg <= '0;
        end else if (bus.flush) begin
            count_reg  <= '0;
            result_reg <= '0;
        end else if (accept) begin
            funct3_reg <= bus.op_funct3;
            neg_reg    <= neg_in;
            count_reg  <= CW'(XLEN-1);
            hi_reg     <= '0;
            m_reg      <= bus.op_funct3[2] ? abs2 : abs1;
            lo_reg     <= bus.op_funct3[2] ? abs1 : abs2;
            if (fast)
                result_reg <= fast_result;
        end else if (state_reg == BUSY) begin
            hi_reg <= hi_step;
            lo_reg <= lo_step;
            if (count_reg == '0)
                result_reg <= result_next;
            else
                count_reg <= count_reg - 1'b1;
        end
    end
endmodule

// File: tb/tb_rv32im_muldiv.sv
// Scoreboard bench for rv32im_muldiv: expected results are queued at issue time and
// compared when the unit responds; control scenarios (reset, flush, backpressure) checked inline.
module tb_rv32im_muldiv;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rv32im_muldiv_if #(.XLEN(32)) bus ();
    rv32im_muldiv #(.XLEN(32)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } txn_t;

    txn_t scb[$];
    int n_vec = 0;
    int n_err = 0;

    // Reference behaviour from plain 64-bit arithmetic.
    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb2, ua, ub;
        logic [63:0] p;
        sa  = longint'($signed(a));
        sb2 = longint'($signed(b));
        ua  = longint'({32'd0, a});
        ub  = longint'({32'd0, b});
        case (f)
            3'd0: begin p = 64'(ua * ub);  return p[31:0];  end
            3'd1: begin p = 64'(sa * sb2); return p[63:32]; end
            3'd2: begin p = 64'(sa * ub);  return p[63:32]; end
            3'd3: begin p = 64'(ua * ub);  return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
                p = 64'(sa / sb2); return p[31:0];
            end
            3'd5: return (b == 32'd0) ? 32'hFFFFFFFF : a / b;
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
                p = 64'(sa % sb2); return p[31:0];
            end
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        bus.op_funct3 = f;
        bus.operand_1 = a;
        bus.operand_2 = b;
        bus.req_valid = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.op_funct3 = 3'($urandom);
        bus.operand_1 = $urandom;
        bus.operand_2 = $urandom;
    endtask

    task automatic wait_resp(output logic [31:0] r, output int lat);
        r   = 'x;
        lat = -1;
        for (int c = 1; c <= 100; c++) begin
            @(posedge clk); #1;
            if (bus.resp_valid) begin
                r   = bus.result;
                lat = c;
                break;
            end
        end
    endtask

    task automatic consume();
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        bus.resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        logic seen;
        #2;
        n_vec++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL reset_req_ready got=%b exp=1", bus.req_ready); end
        n_vec++; if (bus.resp_valid !== 1'b0) begin n_err++; $display("FAIL reset_resp_valid got=%b exp=0", bus.resp_valid); end
        n_vec++; if (bus.result !== 32'd0) begin n_err++; $display("FAIL reset_result got=%h exp=00000000", bus.result); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        issue(3'd5, 32'd100, 32'd7);
        repeat (9) begin @(posedge clk); #1; end
        #2 rst = 1'b1;
        #1;
        n_vec++; if (bus.resp_valid !== 1'b0) begin n_err++; $display("FAIL midbusy_reset_resp_valid got=%b exp=0", bus.resp_valid); end
        n_vec++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL midbusy_reset_req_ready got=%b exp=1", bus.req_ready); end
        n_vec++; if (bus.result !== 32'd0) begin n_err++; $display("FAIL midbusy_reset_result got=%h exp=00000000", bus.result); end
        #1 rst = 1'b0;
        @(posedge clk); #1;
        seen = 1'b0;
        repeat (40) begin @(posedge clk); #1; if (bus.resp_valid) seen = 1'b1; end
        n_vec++; if (seen !== 1'b0) begin n_err++; $display("FAIL midbusy_reset_stale_resp got=%b exp=0", seen); end
        $display("txn reset mid-BUSY DIVU 100/7 abandoned");
    endtask

    task automatic test_mul();
        logic [2:0]  f[4] = '{3'd0, 3'd1, 3'd3, 3'd2};
        logic [31:0] a[4] = '{32'd7, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] b[4] = '{32'hFFFFFFFD, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'd2};
        logic [31:0] e[4] = '{32'hFFFFFFEB, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFF};
        logic [31:0] r;
        int lat;
        txn_t t;
        for (int i = 0; i < 4; i++) begin
            scb.push_back('{f[i], a[i], b[i], e[i], 32});
            issue(f[i], a[i], b[i]);
            wait_resp(r, lat);
            t = scb.pop_front();
            $display("txn mul f=%0d a=%h b=%h result=%h lat=%0d", t.f, t.a, t.b, r, lat);
            n_vec++; if (r !== t.exp) begin n_err++; $display("FAIL mul_result f=%0d got=%h exp=%h", t.f, r, t.exp); end
            n_vec++; if (lat !== t.lat) begin n_err++; $display("FAIL mul_latency f=%0d got=%0d exp=%0d", t.f, lat, t.lat); end
            consume();
        end
    endtask

    task automatic test_div();
        logic [2:0]  f[4] = '{3'd4, 3'd6, 3'd5, 3'd7};
        logic [31:0] a[4] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100};
        logic [31:0] b[4] = '{32'd2, 32'd2, 32'd7, 32'd7};
        logic [31:0] e[4] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2};
        logic [31:0] r;
        int lat;
        txn_t t;
        for (int i = 0; i < 4; i++) begin
            scb.push_back('{f[i], a[i], b[i], e[i], 32});
            issue(f[i], a[i], b[i]);
            wait_resp(r, lat);
            t = scb.pop_front();
            $display("txn div f=%0d a=%h b=%h result=%h lat=%0d", t.f, t.a, t.b, r, lat);
            n_vec++; if (r !== t.exp) begin n_err++; $display("FAIL div_result f=%0d got=%h exp=%h", t.f, r, t.exp); end
            n_vec++; if (lat !== t.lat) begin n_err++; $display("FAIL div_latency f=%0d got=%0d exp=%0d", t.f, lat, t.lat); end
            consume();
        end
    endtask

    task automatic test_fast_path();
        logic [2:0]  f[4] = '{3'd5, 3'd6, 3'd4, 3'd6};
        logic [31:0] a[4] = '{32'd5, 32'd5, 32'h80000000, 32'h80000000};
        logic [31:0] b[4] = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] e[4] = '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0};
        logic [31:0] r;
        int lat;
        txn_t t;
        for (int i = 0; i < 4; i++) begin
            scb.push_back('{f[i], a[i], b[i], e[i], 1});
            issue(f[i], a[i], b[i]);
            wait_resp(r, lat);
            t = scb.pop_front();
            $display("txn fast f=%0d a=%h b=%h result=%h lat=%0d", t.f, t.a, t.b, r, lat);
            n_vec++; if (r !== t.exp) begin n_err++; $display("FAIL fast_result f=%0d got=%h exp=%h", t.f, r, t.exp); end
            n_vec++; if (lat !== t.lat) begin n_err++; $display("FAIL fast_latency f=%0d got=%0d exp=%0d", t.f, lat, t.lat); end
            consume();
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] r;
        int lat;
        txn_t t;
        scb.push_back('{3'd7, 32'd100, 32'd7, 32'd2, 32});
        issue(3'd7, 32'd100, 32'd7);
        wait_resp(r, lat);
        t = scb.pop_front();
        n_vec++; if (r !== t.exp) begin n_err++; $display("FAIL bp_result got=%h exp=%h", r, t.exp); end
        // A competing request is offered throughout the hold and must not be taken.
        bus.op_funct3 = 3'd0; bus.operand_1 = 32'd9; bus.operand_2 = 32'd9; bus.req_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            n_vec++; if (bus.result !== t.exp) begin n_err++; $display("FAIL bp_hold_result cyc=%0d got=%h exp=%h", c, bus.result, t.exp); end
            n_vec++; if (bus.resp_valid !== 1'b1) begin n_err++; $display("FAIL bp_hold_valid cyc=%0d got=%b exp=1", c, bus.resp_valid); end
            n_vec++; if (bus.req_ready !== 1'b0) begin n_err++; $display("FAIL bp_hold_ready cyc=%0d got=%b exp=0", c, bus.req_ready); end
        end
        consume();
        bus.req_valid = 1'b0;
        n_vec++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_ready got=%b exp=1", bus.req_ready); end
        n_vec++; if (bus.resp_valid !== 1'b0) begin n_err++; $display("FAIL bp_release_valid got=%b exp=0", bus.resp_valid); end
        $display("txn backpressure REMU 100/7 held 20 cycles result=%h", r);
    endtask

    task automatic test_back_to_back();
        int n = 12;
        int issued = 0;
        int got = 0;
        logic [2:0]  f;
        logic [31:0] a, b;
        txn_t t;
        bus.resp_ready = 1'b1;
        fork
            begin
                for (int c = 0; c < 3000 && issued < n; c++) begin
                    if (bus.req_ready) begin
                        f = 3'($urandom);
                        a = $urandom;
                        case ($urandom_range(0, 4))
                            0:       b = 32'd0;
                            1:       begin a = 32'h80000000; b = 32'hFFFFFFFF; end
                            2:       b = 32'($urandom_range(1, 50));
                            default: b = $urandom;
                        endcase
                        scb.push_back('{f, a, b, model(f, a, b), 0});
                        issue(f, a, b);
                        issued++;
                    end
                    @(posedge clk); #1;
                end
            end
            begin
                for (int c = 0; c < 3000 && got < n; c++) begin
                    @(posedge clk); #1;
                    if (bus.resp_valid) begin
                        t = scb.pop_front();
                        $display("txn b2b f=%0d a=%h b=%h result=%h", t.f, t.a, t.b, bus.result);
                        n_vec++; if (bus.result !== t.exp) begin n_err++; $display("FAIL b2b_result f=%0d a=%h b=%h got=%h exp=%h", t.f, t.a, t.b, bus.result, t.exp); end
                        got++;
                    end
                end
            end
        join
        bus.resp_ready = 1'b0;
        n_vec++; if (got !== n) begin n_err++; $display("FAIL b2b_count got=%0d exp=%0d", got, n); end
    endtask

    task automatic test_flush();
        logic [31:0] r;
        int lat;
        logic seen;
        txn_t t;
        issue(3'd0, 32'd5, 32'd6);
        repeat (4) begin @(posedge clk); #1; end
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        n_vec++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL flush_busy_ready got=%b exp=1", bus.req_ready); end
        n_vec++; if (bus.resp_valid !== 1'b0) begin n_err++; $display("FAIL flush_busy_valid got=%b exp=0", bus.resp_valid); end
        seen = 1'b0;
        repeat (40) begin @(posedge clk); #1; if (bus.resp_valid) seen = 1'b1; end
        n_vec++; if (seen !== 1'b0) begin n_err++; $display("FAIL flush_busy_stale_resp got=%b exp=0", seen); end
        $display("txn flush at BUSY cycle 5 of MUL 5*6");

        issue(3'd5, 32'd100, 32'd7);
        wait_resp(r, lat);
        n_vec++; if (r !== 32'd14) begin n_err++; $display("FAIL flush_done_pre_result got=%h exp=0000000e", r); end
        bus.flush = 1'b1;
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        bus.resp_ready = 1'b0;
        n_vec++; if (bus.resp_valid !== 1'b0) begin n_err++; $display("FAIL flush_done_valid got=%b exp=0", bus.resp_valid); end
        n_vec++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL flush_done_ready got=%b exp=1", bus.req_ready); end
        $display("txn flush in DONE with resp_ready of DIVU 100/7");

        // Flush coinciding with a request in IDLE: nothing may be accepted.
        bus.flush = 1'b1;
        bus.op_funct3 = 3'd0; bus.operand_1 = 32'd8; bus.operand_2 = 32'd8; bus.req_valid = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        bus.req_valid = 1'b0;
        n_vec++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL flush_vs_accept_ready got=%b exp=1", bus.req_ready); end
        seen = 1'b0;
        repeat (40) begin @(posedge clk); #1; if (bus.resp_valid) seen = 1'b1; end
        n_vec++; if (seen !== 1'b0) begin n_err++; $display("FAIL flush_vs_accept_resp got=%b exp=0", seen); end
        $display("txn flush with simultaneous request, nothing accepted");

        scb.push_back('{3'd0, 32'd3, 32'd4, 32'd12, 32});
        issue(3'd0, 32'd3, 32'd4);
        wait_resp(r, lat);
        t = scb.pop_front();
        $display("txn post-flush MUL 3*4 result=%h lat=%0d", r, lat);
        n_vec++; if (r !== t.exp) begin n_err++; $display("FAIL post_flush_result got=%h exp=%h", r, t.exp); end
        n_vec++; if (lat !== t.lat) begin n_err++; $display("FAIL post_flush_latency got=%0d exp=%0d", lat, t.lat); end
        consume();
    endtask

    initial begin
        bus.flush      = 1'b0;
        bus.req_valid  = 1'b0;
        bus.op_funct3  = 3'd0;
        bus.operand_1  = 32'd0;
        bus.operand_2  = 32'd0;
        bus.resp_ready = 1'b0;
        test_reset();
        test_mul();
        test_div();
        test_fast_path();
        test_backpressure();
        test_back_to_back();
        test_flush();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
